bus_loader: RTL

BUS_LOADER -- requirements
Module: bus_loader

---
 rtl/bus_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bus_loader.sv
// rtl/bus_loader.sv - streams a length-prefixed byte image into 32-bit memory writes while holding the CPU in reset
// Optional trailing XOR checksum byte: define BUS_LOADER_CHECKSUM_EN.
module bus_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        bus_oe,
   output logic        cpu_rst,
   output logic        done,
   output logic        err,
   output logic [15:0] word_count
);

`ifdef BUS_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] len_q, len_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] wcount_q, wcount_d;
   logic        err_q, err_d;
   logic        run_q;
   logic        accept;
   logic [31:0] len_full;
   logic [15:0] wcount_inc;
`ifdef BUS_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   // run_q keeps in_ready low until the first edge after reset is released
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_LEN;
         cnt_q    <= 2'd0;
         len_q    <= 32'd0;
         wdata_q  <= 32'd0;
         addr_q   <= BASE_ADDR;
         wcount_q <= 16'd0;
         err_q    <= 1'b0;
         run_q    <= 1'b0;
`ifdef BUS_LOADER_CHECKSUM_EN
         csum_q   <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         wdata_q  <= wdata_d;
         addr_q   <= addr_d;
         wcount_q <= wcount_d;
         err_q    <= err_d;
         run_q    <= 1'b1;
`ifdef BUS_LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      wdata_d    = wdata_q;
      addr_d     = addr_q;
      wcount_d   = wcount_q;
      err_d      = err_q;
`ifdef BUS_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      in_ready   = 1'b0;
      len_full   = {in_data, len_q[31:8]};
      wcount_inc = wcount_q + 16'd1;

      case (state_q)
         S_LEN, S_DATA: in_ready = run_q;
`ifdef BUS_LOADER_CHECKSUM_EN
         S_CHK:         in_ready = run_q;
`endif
         default:       in_ready = 1'b0;
      endcase
      accept = in_valid && in_ready;

      case (state_q)
         // bytes enter at the top and shift down, so the first byte ends up in [7:0]
         S_LEN: begin
            if (accept) begin
               cnt_d = cnt_q + 2'd1;
               len_d = len_full;
               if (cnt_q == 2'd3) begin
                  if (len_full == 32'd0) begin
                     state_d = S_DONE;
                  end else if (len_full > MAX_WORDS) begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               cnt_d   = cnt_q + 2'd1;
               wdata_d = {in_data, wdata_q[31:8]};
`ifdef BUS_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ in_data;
`endif
               if (cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            addr_d   = addr_q + 32'd4;
            wcount_d = wcount_inc;
            if ({16'd0, wcount_inc} == len_q) begin
`ifdef BUS_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef BUS_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               if (in_data != csum_q) begin
                  err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
`endif
         default: ;
      endcase
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_write  = (state_q == S_WRITE);
   assign bus_oe     = (state_q == S_WRITE);
   assign cpu_rst    = (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign err        = err_q;
   assign word_count = wcount_q;

endmodule
